ti_share_encoder: RTL and testbench
===================================

# ti_share_encoder

Input masking stage for the threshold-implementation AES datapath. It accepts unshared data words over a valid/ready handshake and splits each one into four Boolean shares using fresh randomness from an internal 32-bit LFSR. The resulting four-share words feed the shared S-box pipeline, including the stage-2 GF(2^4) inverter. The block also tracks how much randomness has been consumed since the last seed and stalls until it is reseeded.

## Interface
- WIDTH, 8, data/share width in bits; legal values 4 or 8, so that 3*WIDTH <= 32.
- RESEED_CNT, 1024, number of accepted words allowed per seed; must be >= 1.

- ClkxCI  in  1  clock; all state updates on the rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- SeedxDI  in  32  LFSR seed value.
- SeedValidxSI  in  1  loads SeedxDI this cycle; no ready signal, always accepted.
- ReseedReqxSO  out  1  high when the block is unseeded or its randomness budget is exhausted.
- XxDI  in  WIDTH  unshared input word.
- InValidxSI  in  1  input valid.
- InReadyxSO  out  1  input ready.
- QxDO0, QxDO1, QxDO2, QxDO3  out  WIDTH each  output shares; their XOR equals the input word.
- OutValidxSO  out  1  output valid.
- OutReadyxSI  in  1  output ready.

## Operation
- FSM has three states: UNSEEDED (reset state), RUN, EXHAUSTED.
  - UNSEEDED -> RUN on SeedValidxSI.
  - RUN -> EXHAUSTED when an acceptance makes the counter equal RESEED_CNT.
  - EXHAUSTED -> RUN on SeedValidxSI.
  - SeedValidxSI in RUN stays in RUN and clears the counter.
- Seed load: the LFSR takes SeedxDI. A seed of 0 loads 32'h0000_0001 instead. The counter clears to 0.
- LFSR single step: nb = s[31]^s[21]^s[1]^s[0]; s <= {s[30:0], nb}.
- Masks come from the current state s: R0 = s[W-1:0], R1 = s[2W-1:W], R2 = s[3W-1:2W].
- Shares: Q0 = R0, Q1 = R1, Q2 = R2, Q3 = X^R0^R1^R2.
- Acceptance occurs when InValidxSI && InReadyxSO. On acceptance:
  - the share register loads;
  - the LFSR advances exactly 3*WIDTH single steps in one cycle (combinational unroll);
  - the counter increments.
- The LFSR never advances without an acceptance.
- Simultaneous acceptance and seed in the same cycle:
  - the accepted word uses the old masks;
  - the LFSR loads the seed (seed wins over advance);
  - the counter is set to 0, not 1.
- InReadyxSO = (state == RUN) && (!OutValidxSO || OutReadyxSI).
- ReseedReqxSO = (state != RUN).
- The output register holds a single entry:
  - OutValidxSO sets on acceptance;
  - it clears on OutValidxSI-side handshake (OutValidxSO && OutReadyxSI) when there is no new acceptance in that cycle.
- Words already in the output register drain normally in EXHAUSTED and UNSEEDED states.
- Counter width is $clog2(RESEED_CNT+1). It never exceeds RESEED_CNT.

## Timing
- Latency is 1 cycle from acceptance to OutValidxSO with the shares.
- Throughput is 1 word per cycle under continuous OutReadyxSI in RUN.
- While OutValidxSO=1 and OutReadyxSI=0, QxDO0..3 are stable.
- A seed takes effect the cycle after SeedValidxSI. InReadyxSO may assert in that next cycle.
- Reset values: OutValidxSO=0, QxDO0..3=0, LFSR=0, counter=0, state UNSEEDED, InReadyxSO=0, ReseedReqxSO=1.
- Asserting RstxBI mid-stream immediately discards the pending output word and returns the block to UNSEEDED.
- Shares are registered. No output share is a combinational function of XxDI.

## Structure
- Package ti_pkg holds:
  - LFSR_W = 32;
  - tap positions {31, 21, 1, 0};
  - SEED_ZERO_SUB = 32'h1;
  - the FSM state enum (UNSEEDED, RUN, EXHAUSTED).
- Sub-module ti_lfsr32 holds the state register with a seed load port, an advance-enable port and a parameterised step count (3*WIDTH). It exposes the current state.
- The top level holds the FSM, the counter, the output register and the handshake logic.

## Test plan
- After reset with no seed: InReadyxSO=0, ReseedReqxSO=1, OutValidxSO=0, all QxDO=0, including while InValidxSI=1.
- Seed 32'h00000001, then X=8'hA5 -> next cycle OutValidxSO=1, Q0=8'h01, Q1=8'h00, Q2=8'h00, Q3=8'hA4.
- Seed 32'h00000000, then X=8'hA5 -> output identical to the previous case.
- Stream 1000 random words with random OutReadyxSI backpressure:
  - XOR of the four shares equals each input, in order, with no loss or duplication;
  - shares are stable while stalled;
  - the LFSR sequence matches the model and does not advance during stalls.
- RESEED_CNT=4:
  - after 4 acceptances, InReadyxSO=0 and ReseedReqxSO=1, and the 4th word still drains;
  - seed 32'hDEADBEEF -> InReadyxSO=1 the next cycle and the counter restarts;
  - seed in the same cycle as an acceptance -> that word uses the old masks.
- Assert RstxBI while OutValidxSO=1 -> OutValidxSO=0 and QxDO=0 immediately, state UNSEEDED, ReseedReqxSO=1.

Source files
------------

// File: rtl/ti_pkg.sv
// Shared constants, FSM state type and LFSR step helper for the TI share encoder.
package ti_pkg;

  localparam int unsigned LFSR_W = 32;

  // Feedback taps of the x^32 + x^22 + x^2 + x + 1 style Fibonacci LFSR.
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_UNSEEDED  = 2'd0,
    ST_RUN       = 2'd1,
    ST_EXHAUSTED = 2'd2
  } state_e;

  // One shift of the LFSR: new bit enters at the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic nb;
    nb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[LFSR_W-2:0], nb};
  endfunction

endpackage

// File: rtl/ti_lfsr32.sv
// 32-bit randomness source: seed load, or STEPS unrolled shifts per advance.
module ti_lfsr32
  import ti_pkg::*;
#(
  parameter int unsigned STEPS = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] adv_c;

  // Combinational unroll of STEPS single shifts.
  always_comb begin
    adv_c = state_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv_c = lfsr_step(adv_c);
    end
  end

  // State register; a seed load takes priority over an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (load) begin
      state_q <= (seed == '0) ? SEED_ZERO_SUB : seed;
    end else if (adv) begin
      state_q <= adv_c;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ti_share_encoder.sv
// Splits unshared words into four Boolean shares with LFSR masks and a reseed budget.
module ti_share_encoder
  import ti_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RESEED_CNT = 1024
) (
  input  logic             ClkxCI,
  input  logic             RstxBI,
  input  logic [31:0]      SeedxDI,
  input  logic             SeedValidxSI,
  output logic             ReseedReqxSO,
  input  logic [WIDTH-1:0] XxDI,
  input  logic             InValidxSI,
  output logic             InReadyxSO,
  output logic [WIDTH-1:0] QxDO0,
  output logic [WIDTH-1:0] QxDO1,
  output logic [WIDTH-1:0] QxDO2,
  output logic [WIDTH-1:0] QxDO3,
  output logic             OutValidxSO,
  input  logic             OutReadyxSI
);

  localparam int unsigned MASK_W = 3 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(RESEED_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_CNT);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [LFSR_W-1:0] lfsr_s;
  logic              accept;
  logic [WIDTH-1:0]  r0;
  logic [WIDTH-1:0]  r1;
  logic [WIDTH-1:0]  r2;
  logic              unused_lfsr;

  ti_lfsr32 #(
    .STEPS(MASK_W)
  ) u_lfsr (
    .clk  (ClkxCI),
    .rst_n(RstxBI),
    .load (SeedValidxSI),
    .seed (SeedxDI),
    .adv  (accept),
    .state(lfsr_s)
  );

  // Masks are taken from the current LFSR state; upper bits are not needed.
  assign r0          = lfsr_s[WIDTH-1:0];
  assign r1          = lfsr_s[2*WIDTH-1:WIDTH];
  assign r2          = lfsr_s[MASK_W-1:2*WIDTH];
  assign unused_lfsr = ^lfsr_s[LFSR_W-1:MASK_W];

  assign InReadyxSO   = (state_q == ST_RUN) && (!OutValidxSO || OutReadyxSI);
  assign ReseedReqxSO = (state_q != ST_RUN);
  assign accept       = InValidxSI && InReadyxSO;

  // FSM state register.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= ST_UNSEEDED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a seed always (re)enters RUN; budget exhaustion leaves it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNSEEDED: begin
        if (SeedValidxSI) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!SeedValidxSI && accept && (cnt_q + CNT_W'(1) == CNT_MAX)) begin
          state_d = ST_EXHAUSTED;
        end
      end
      ST_EXHAUSTED: begin
        if (SeedValidxSI) state_d = ST_RUN;
      end
      default: state_d = ST_UNSEEDED;
    endcase
  end

  // Words accepted since the last seed; a seed in the same cycle wins.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      cnt_q <= '0;
    end else if (SeedValidxSI) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Single-entry output register holding the shares.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      OutValidxSO <= 1'b0;
      QxDO0       <= '0;
      QxDO1       <= '0;
      QxDO2       <= '0;
      QxDO3       <= '0;
    end else if (accept) begin
      OutValidxSO <= 1'b1;
      QxDO0       <= r0;
      QxDO1       <= r1;
      QxDO2       <= r2;
      QxDO3       <= XxDI ^ r0 ^ r1 ^ r2;
    end else if (OutValidxSO && OutReadyxSI) begin
      OutValidxSO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ti_share_encoder.sv
// Randomized scoreboard bench for ti_share_encoder with a small reseed budget.
module tb_ti_share_encoder;

  localparam int unsigned W  = 8;
  localparam int unsigned RC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  seed = '0;
  logic         seed_valid = 1'b0;
  logic         reseed_req;
  logic [W-1:0] x = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] q0, q1, q2, q3;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int accepted = 0;

  // Reference model: LFSR contents, words since seed, seeded flag.
  logic [31:0] m_s = '0;
  int          m_cnt = 0;
  bit          m_seeded = 1'b0;
  logic [31:0] exp_q[$];

  ti_share_encoder #(.WIDTH(W), .RESEED_CNT(RC)) dut (
    .ClkxCI      (clk),
    .RstxBI      (rst_n),
    .SeedxDI     (seed),
    .SeedValidxSI(seed_valid),
    .ReseedReqxSO(reseed_req),
    .XxDI        (x),
    .InValidxSI  (in_valid),
    .InReadyxSO  (in_ready),
    .QxDO0       (q0),
    .QxDO1       (q1),
    .QxDO2       (q2),
    .QxDO3       (q3),
    .OutValidxSO (out_valid),
    .OutReadyxSI (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // 3*W polynomial steps of x^32+x^22+x^2+x+1 sequence.
  function automatic logic [31:0] model_advance(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < 3 * W; k++) begin
      t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    end
    return t;
  endfunction

  function automatic bit model_running();
    return m_seeded && (m_cnt < RC);
  endfunction

  // One clock of stimulus; expected shares are queued on acceptance.
  task automatic drive(input bit iv, input logic [W-1:0] xv, input bit orr,
                       input bit sv, input logic [31:0] sd, output bit acc);
    logic [W-1:0] r0, r1, r2;
    @(negedge clk);
    in_valid   = iv;
    x          = xv;
    out_ready  = orr;
    seed_valid = sv;
    seed       = sd;
    #1;
    chk("reseed_req", 32'(reseed_req), 32'(!model_running()));
    chk("in_ready", 32'(in_ready), 32'(model_running() && (!out_valid || out_ready)));
    acc = iv && in_ready;
    if (acc) begin
      r0 = m_s[7:0];
      r1 = m_s[15:8];
      r2 = m_s[23:16];
      exp_q.push_back({xv ^ r0 ^ r1 ^ r2, r2, r1, r0});
      accepted++;
    end
    if (sv) begin
      m_s      = (sd == 32'h0) ? 32'h1 : sd;
      m_cnt    = 0;
      m_seeded = 1'b1;
    end else if (acc) begin
      m_s = model_advance(m_s);
      m_cnt++;
    end
  endtask

  // Monitor: compares each presented output against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {q3, q2, q1, q0}, 32'hxxxx_xxxx);
        end else begin
          chk("shares", {q3, q2, q1, q0}, exp_q[0]);
          chk("share_xor", 32'(q0 ^ q1 ^ q2 ^ q3),
              32'(exp_q[0][7:0] ^ exp_q[0][15:8] ^ exp_q[0][23:16] ^ exp_q[0][31:24]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc;
    int cyc;
    logic [31:0] sd;

    // Reset with a pending input request: nothing may move.
    in_valid = 1'b1;
    x = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_reseed_req", 32'(reseed_req), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", {q3, q2, q1, q0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unseeded: input stays blocked and outputs stay zero.
    drive(1, 8'h33, 1, 0, 0, acc);
    drive(1, 8'h33, 1, 0, 0, acc);
    #2;
    chk("unseeded_q", {q3, q2, q1, q0}, 32'h0);

    // Seed 1 then A5 -> shares 01,00,00,A4.
    drive(0, 8'h00, 1, 1, 32'h1, acc);
    drive(1, 8'hA5, 1, 0, 0, acc);
    @(posedge clk);
    #1;
    chk("seed1_valid", 32'(out_valid), 32'd1);
    chk("seed1_q", {q3, q2, q1, q0}, 32'hA400_0001);
    drive(0, 8'h00, 1, 0, 0, acc);

    // Zero seed behaves like seed 1.
    drive(0, 8'h00, 1, 1, 32'h0, acc);
    drive(1, 8'hA5, 1, 0, 0, acc);
    @(posedge clk);
    #1;
    chk("seed0_q", {q3, q2, q1, q0}, 32'hA400_0001);
    drive(0, 8'h00, 1, 0, 0, acc);

    // Budget exhaustion, reseed, and seed coinciding with an acceptance.
    drive(0, 8'h00, 1, 1, 32'hDEAD_BEEF, acc);
    for (int i = 0; i < RC; i++) drive(1, W'($urandom), 1, 0, 0, acc);
    drive(1, 8'h11, 0, 0, 0, acc);
    chk("exhausted_no_accept", 32'(acc), 32'd0);
    drive(1, 8'h22, 1, 1, 32'hDEAD_BEEF, acc);
    drive(1, 8'h44, 1, 0, 0, acc);
    chk("reseed_accept", 32'(acc), 32'd1);
    drive(1, 8'h66, 1, 1, 32'h1234_5678, acc);
    chk("seed_with_accept", 32'(acc), 32'd1);
    for (int i = 0; i < RC + 1; i++) drive(1, W'($urandom), 1, 0, 0, acc);

    // Random stream with backpressure and random reseeds.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      sd = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      if (!model_running())
        drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 9) < 7,
              $urandom_range(0, 1) == 1, sd, acc);
      else
        drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 9) < 7,
              $urandom_range(0, 29) == 0, sd, acc);
      cyc++;
    end
    chk("stream_count", 32'(accepted >= 1000), 32'd1);
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 1, 0, 0, acc);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a word is pending in the output register.
    drive(0, 8'h00, 1, 1, 32'hCAFE_F00D, acc);
    drive(1, 8'h77, 0, 0, 0, acc);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    m_s = '0;
    m_cnt = 0;
    m_seeded = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_q", {q3, q2, q1, q0}, 32'h0);
    chk("midrst_reseed_req", 32'(reseed_req), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'h77, 1, 0, 0, acc);
    drive(0, 8'h00, 1, 1, 32'h0BAD_5EED, acc);
    drive(1, 8'h99, 1, 0, 0, acc);
    drive(0, 8'h00, 1, 0, 0, acc);
    drive(0, 8'h00, 1, 0, 0, acc);
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
